circle_scheduler: RTL and testbench

Command scheduler for the circle drawing engine in the VGA core. Buffers up to DEPTH circle-draw requests from the GUI control logic in a FIFO and issues them to the engine one at a time over its start/done handshake. Holds the engine's centre, radius and colour inputs stable for the whole draw, and reports queue occupancy and a completed-draw count. Sits between the GUI command logic and the circle engine; the engine's VGA pixel outputs do not pass through this block.

---
 rtl/circle_scheduler.sv | 179 +++++++++++++++++
 tb/tb_circle_scheduler.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/circle_scheduler.sv
// -----------------------------------------------------------------------------
// circle_scheduler
//
// Queues circle-draw requests from the GUI command logic in a DEPTH-entry FIFO
// and issues them one at a time to the circle engine over its start/done
// handshake. The engine parameters are held stable for the whole draw.
//
// Ports
//   clk, rst_n           rising-edge clock, asynchronous active-low reset
//   cmd_valid/cmd_ready  request handshake (ready = !full && !flush)
//   cmd_cx/cy/radius/colour  request payload
//   flush                discard every queued, not-yet-issued request
//   eng_start/eng_done   engine handshake
//   eng_cx/cy/radius/colour  parameters of the draw in progress
//   busy                 scheduler is not idle
//   pending              queued requests, excluding the one being drawn
//   drawn_count          completed draws, wraps modulo 2^CNT_W
// -----------------------------------------------------------------------------
module circle_scheduler #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [7:0]               cmd_cx,
    input  logic [6:0]               cmd_cy,
    input  logic [7:0]               cmd_radius,
    input  logic [2:0]               cmd_colour,
    input  logic                     flush,
    output logic                     eng_start,
    input  logic                     eng_done,
    output logic [7:0]               eng_cx,
    output logic [6:0]               eng_cy,
    output logic [7:0]               eng_radius,
    output logic [2:0]               eng_colour,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   pending,
    output logic [CNT_W-1:0]         drawn_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned EW = 8 + 7 + 8 + 3;

    typedef logic [EW-1:0] entry_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // FIFO storage and pointers
    // -------------------------------------------------------------------------
    entry_t         mem_q [DEPTH];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]  fill;
    logic           full;
    logic           push;
    logic           pop;
    entry_t         head;
    entry_t         cmd_entry;

    // -------------------------------------------------------------------------
    // Control and engine-side registers
    // -------------------------------------------------------------------------
    state_t             state_q, state_d;
    logic               eng_start_q, eng_start_d;
    logic               busy_q, busy_d;
    entry_t             eng_q, eng_d;
    logic [CNT_W-1:0]   drawn_q, drawn_d;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign fill      = wr_ptr_q - rd_ptr_q;
    assign full      = (fill == PW'(DEPTH));
    assign cmd_ready = !full && !flush;
    assign pending   = fill;

    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state_q == ST_IDLE) && (fill != '0) && !flush;

    assign cmd_entry = {cmd_cx, cmd_cy, cmd_radius, cmd_colour};
    assign head      = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            wr_ptr_d = wr_ptr_q + PW'(push);
            rd_ptr_d = rd_ptr_q + PW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= cmd_entry;
        end
    end

    // -------------------------------------------------------------------------
    // Issue FSM
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        eng_d   = eng_q;
        drawn_d = drawn_q;

        unique case (state_q)
            ST_IDLE: begin
                // A done still high here is stale and deliberately ignored.
                if (pop) begin
                    eng_d   = head;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (eng_done) begin
                    drawn_d = drawn_q + CNT_W'(1);
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Wait for the engine to return to its init state before the
                // next start, otherwise the old done would end the next draw.
                if (!eng_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered from the next state so they change exactly
        // with the state transition.
        eng_start_d = (state_d == ST_RUN);
        busy_d      = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            eng_start_q <= 1'b0;
            busy_q      <= 1'b0;
            eng_q       <= '0;
            drawn_q     <= '0;
        end else begin
            state_q     <= state_d;
            eng_start_q <= eng_start_d;
            busy_q      <= busy_d;
            eng_q       <= eng_d;
            drawn_q     <= drawn_d;
        end
    end

    assign eng_start   = eng_start_q;
    assign busy        = busy_q;
    assign drawn_count = drawn_q;
    assign {eng_cx, eng_cy, eng_radius, eng_colour} = eng_q;

endmodule

// File: tb/tb_circle_scheduler.sv
// -----------------------------------------------------------------------------
// tb_circle_scheduler
//
// Directed scenarios plus a randomized phase for circle_scheduler. A queue-based
// reference model and a behavioural circle-engine model live in the bench; all
// DUT outputs are compared against the model on every falling clock edge.
// -----------------------------------------------------------------------------
module tb_circle_scheduler;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = 3;
    localparam int unsigned PW    = $clog2(DEPTH) + 1;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               cmd_valid;
    logic               cmd_ready;
    logic [7:0]         cmd_cx;
    logic [6:0]         cmd_cy;
    logic [7:0]         cmd_radius;
    logic [2:0]         cmd_colour;
    logic               flush;
    logic               eng_start;
    logic               eng_done;
    logic [7:0]         eng_cx;
    logic [6:0]         eng_cy;
    logic [7:0]         eng_radius;
    logic [2:0]         eng_colour;
    logic               busy;
    logic [PW-1:0]      pending;
    logic [CNT_W-1:0]   drawn_count;

    always #5 clk = ~clk;

    circle_scheduler #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_cx      (cmd_cx),
        .cmd_cy      (cmd_cy),
        .cmd_radius  (cmd_radius),
        .cmd_colour  (cmd_colour),
        .flush       (flush),
        .eng_start   (eng_start),
        .eng_done    (eng_done),
        .eng_cx      (eng_cx),
        .eng_cy      (eng_cy),
        .eng_radius  (eng_radius),
        .eng_colour  (eng_colour),
        .busy        (busy),
        .pending     (pending),
        .drawn_count (drawn_count)
    );

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    // Reference model: queue of waiting requests, request being drawn,
    // draw phase (0 idle, 1 engine started, 2 waiting for done to fall).
    logic [25:0]  mq[$];
    logic [25:0]  cur;
    int           phase;
    int unsigned  drawn;
    bit           last_push;

    // Behavioural engine.
    int  eng_lat;
    int  fall_lat;
    bit  rand_lat;
    int  eng_cnt;
    int  fall_cnt;
    bit  eng_busy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ok(input string tag, input bit ok);
        n_cmp++;
        assert (ok) else begin
            n_err++;
            $error("FAIL %s: wait bound expired (observed 0 expected 1)", tag);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        cur       = '0;
        phase     = 0;
        drawn     = 0;
        last_push = 1'b0;
    endtask

    task automatic model_edge();
        bit rdy;
        bit do_pop;
        if (!rst_n) begin
            model_reset();
            return;
        end
        rdy       = (mq.size() < int'(DEPTH)) && !flush;
        do_pop    = (phase == 0) && (mq.size() > 0) && !flush;
        last_push = cmd_valid && rdy;
        if (flush) begin
            mq.delete();
        end else begin
            if (do_pop)    cur = mq.pop_front();
            if (last_push) mq.push_back({cmd_cx, cmd_cy, cmd_radius, cmd_colour});
        end
        case (phase)
            0: if (do_pop) phase = 1;
            1: if (eng_done) begin phase = 2; drawn++; end
            2: if (!eng_done) phase = 0;
            default: phase = 0;
        endcase
    endtask

    task automatic check_all();
        chk("eng_start",   {31'd0, eng_start}, {31'd0, phase == 1});
        chk("busy",        {31'd0, busy},      {31'd0, phase != 0});
        chk("pending",     32'(pending),       32'(mq.size()));
        chk("cmd_ready",   {31'd0, cmd_ready}, {31'd0, (mq.size() < int'(DEPTH)) && !flush});
        chk("drawn_count", 32'(drawn_count),   drawn % (1 << CNT_W));
        chk("eng_params",  32'({eng_cx, eng_cy, eng_radius, eng_colour}), 32'(cur));
    endtask

    task automatic engine_update();
        if (!rst_n) begin
            eng_done = 1'b0;
            eng_busy = 1'b0;
            return;
        end
        if (!eng_busy && !eng_done && eng_start) begin
            eng_busy = 1'b1;
            eng_cnt  = rand_lat ? int'($urandom_range(1, 6)) : eng_lat;
        end
        if (eng_busy && !eng_done) begin
            eng_cnt--;
            if (eng_cnt <= 0) begin
                eng_done = 1'b1;
                fall_cnt = rand_lat ? int'($urandom_range(1, 3)) : fall_lat;
            end
        end else if (eng_done && !eng_start) begin
            if (fall_cnt <= 1) begin
                eng_done = 1'b0;
                eng_busy = 1'b0;
            end else begin
                fall_cnt--;
            end
        end
    endtask

    // One clock: model follows the edge, outputs checked on the falling edge,
    // then the engine reacts.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
        engine_update();
    endtask

    task automatic push_cmd(input logic [7:0] cx, input logic [6:0] cy,
                            input logic [7:0] r, input logic [2:0] col);
        bit ok;
        ok         = 1'b0;
        cmd_cx     = cx;
        cmd_cy     = cy;
        cmd_radius = r;
        cmd_colour = col;
        cmd_valid  = 1'b1;
        for (int i = 0; i < 300; i++) begin
            step();
            if (last_push) begin
                ok = 1'b1;
                break;
            end
        end
        cmd_valid = 1'b0;
        if (!ok) chk_ok("push_timeout", ok);
    endtask

    task automatic push_rand();
        push_cmd(8'($urandom), 7'($urandom), 8'($urandom), 3'($urandom));
    endtask

    task automatic wait_idle(input int max_cycles);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            if (phase == 0 && mq.size() == 0 && !eng_done) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        chk_ok("idle_timeout", ok);
    endtask

    initial begin
        int unsigned base;
        bit ok;

        rst_n      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_cx     = '0;
        cmd_cy     = '0;
        cmd_radius = '0;
        cmd_colour = '0;
        flush      = 1'b0;
        eng_done   = 1'b0;
        eng_lat    = 50;
        fall_lat   = 1;
        rand_lat   = 1'b0;
        eng_cnt    = 0;
        fall_cnt   = 0;
        eng_busy   = 1'b0;
        model_reset();

        // Reset values
        repeat (3) step();
        chk("rst_eng_start", {31'd0, eng_start}, 32'd0);
        chk("rst_pending",   32'(pending), 32'd0);
        chk("rst_ready",     {31'd0, cmd_ready}, 32'd1);
        chk("rst_params",    32'({eng_cx, eng_cy, eng_radius, eng_colour}), 32'd0);
        rst_n = 1'b1;
        repeat (2) step();

        // Single command, engine done after 50 cycles
        push_cmd(8'd80, 7'd60, 8'd20, 3'd3);
        step();
        chk("t1_start_after_pop", {31'd0, eng_start}, 32'd1);
        chk("t1_params", 32'({eng_cx, eng_cy, eng_radius, eng_colour}),
            32'({8'd80, 7'd60, 8'd20, 3'd3}));
        wait_idle(200);
        chk("t1_drawn", 32'(drawn_count), 32'd1);
        chk("t1_busy",  {31'd0, busy}, 32'd0);

        // Five back-to-back pushes into a 4-deep FIFO with a slow engine
        eng_lat = 30;
        repeat (5) push_rand();
        chk("t2_pending_full", 32'(pending), 32'd4);
        chk("t2_ready_low",    {31'd0, cmd_ready}, 32'd0);
        wait_idle(1000);
        chk("t2_drawn", 32'(drawn_count), 32'd6);

        // Flush while the 2nd of 4 is drawing; count wraps through 7 -> 0
        eng_lat = 20;
        base    = drawn;
        repeat (4) push_rand();
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (phase == 1 && drawn == base + 1) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        chk_ok("t3_reach_second", ok);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("t3_pending_flushed", 32'(pending), 32'd0);
        chk("t3_still_running",   {31'd0, eng_start}, 32'd1);
        wait_idle(300);
        chk("t3_drawn_wrapped", 32'(drawn_count), (base + 2) % (1 << CNT_W));
        chk("t3_start_low",     {31'd0, eng_start}, 32'd0);

        // Push and pop on the same edge with two queued
        eng_lat = 10;
        repeat (3) push_rand();
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (phase == 0) begin
                ok = 1'b1;
                break;
            end
        end
        chk_ok("t4_reach_idle", ok);
        chk("t4_pending_before", 32'(pending), 32'd2);
        cmd_cx     = 8'hA5;
        cmd_cy     = 7'h2C;
        cmd_radius = 8'h11;
        cmd_colour = 3'd6;
        cmd_valid  = 1'b1;
        step();
        cmd_valid = 1'b0;
        chk("t4_pending_same", 32'(pending), 32'd2);
        wait_idle(300);

        // Stale done while idle is ignored
        eng_done = 1'b1;
        eng_busy = 1'b0;
        fall_cnt = 3;
        repeat (5) step();
        chk("stale_busy", {31'd0, busy}, 32'd0);

        // Reset in the middle of a draw
        eng_lat = 50;
        push_rand();
        repeat (2) step();
        #2 rst_n = 1'b0;
        #1;
        chk("t5_start_rst",   {31'd0, eng_start}, 32'd0);
        chk("t5_pending_rst", 32'(pending), 32'd0);
        chk("t5_drawn_rst",   32'(drawn_count), 32'd0);
        chk("t5_busy_rst",    {31'd0, busy}, 32'd0);
        model_reset();
        eng_done = 1'b0;
        eng_busy = 1'b0;
        @(negedge clk);
        step();
        rst_n = 1'b1;
        push_cmd(8'd10, 7'd20, 8'd5, 3'd1);
        wait_idle(200);
        chk("t5_drawn_after", 32'(drawn_count), 32'd1);

        // Randomized traffic with random engine latency and occasional flush
        rand_lat = 1'b1;
        for (int i = 0; i < 400; i++) begin
            cmd_valid  = 1'($urandom_range(0, 1));
            cmd_cx     = 8'($urandom);
            cmd_cy     = 7'($urandom);
            cmd_radius = 8'($urandom);
            cmd_colour = 3'($urandom);
            flush      = ($urandom_range(0, 39) == 0);
            step();
        end
        cmd_valid = 1'b0;
        flush     = 1'b0;
        wait_idle(500);
        chk("rand_drawn", 32'(drawn_count), drawn % (1 << CNT_W));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
